// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants shared with the sync generator, line fetch geometry, scheduler state type
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_MAX = 799;
  localparam int V_DISPLAY = 480;
  localparam int V_MAX = 524;
  localparam int BURST_LEN = 8;
  localparam int BURSTS_PER_LINE = H_DISPLAY / BURST_LEN;
  localparam int ADDR_W = 24;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/line_addr_gen.sv
// line_addr_gen: SDRAM burst address = registered line base + burst offset
// Ports: clk/reset (async, active-low); load captures base for line;
// burst_idx selects the burst within the line; addr is the burst start word address.
module line_addr_gen
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE = '0,
  parameter int LINE_STRIDE = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [10:0]       line,
  input  logic [6:0]        burst_idx,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] base;
  // The multiply is registered on load; the IDLE->REQ cycle hides that latency.
  always_ff @(posedge clk or negedge reset)
    if (!reset) base <= '0;
    else if (load) base <= FB_BASE + ADDR_W'(line) * ADDR_W'(LINE_STRIDE);
  assign addr = base + ADDR_W'(burst_idx) * ADDR_W'(BURST_LEN);
endmodule

// File: rtl/line_fetch_scheduler.sv
// line_fetch_scheduler: fetches the next scanline into the idle ping-pong half during horizontal blank
// Ports: clk, reset (async, active-low); clk_stb/hpos/vpos from the sync generator;
// enable gates new fetches; rd_req/rd_addr/rd_ack/rd_done form the SDRAM burst handshake;
// wr_buf/burst_idx address the line buffer being filled; disp_buf is the half on screen;
// line_ready marks a complete fetch; underrun is sticky until underrun_clr.
module line_fetch_scheduler
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE = '0,
  parameter int LINE_STRIDE = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_stb,
  input  logic [10:0]       hpos,
  input  logic [10:0]       vpos,
  input  logic              enable,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              wr_buf,
  output logic [6:0]        burst_idx,
  output logic              disp_buf,
  output logic              line_ready,
  output logic              underrun,
  input  logic              underrun_clr
);
  localparam logic [6:0] LAST_IDX = 7'(BURSTS_PER_LINE - 1);
  state_t state, state_nx;
  logic [6:0] idx_nx;
  logic [10:0] tgt, pend_line, pend_line_nx, load_line;
  logic visible, trig, swap, late, load, pend, pend_nx, ready_nx, und_nx;
  // Upcoming line is visible: any line before the last visible one, or the frame wrap.
  assign visible = vpos <= 11'(V_DISPLAY - 2) || vpos == 11'(V_MAX);
  assign trig = clk_stb && enable && visible && hpos == 11'(H_DISPLAY);
  assign swap = clk_stb && visible && hpos == 11'(H_MAX);
  assign late = trig && state != IDLE;
  assign tgt = vpos == 11'(V_MAX) ? 11'd0 : vpos + 11'd1;
  assign rd_req = state == REQ;
  assign wr_buf = ~disp_buf;
  always_comb begin
    state_nx = state;
    idx_nx = burst_idx;
    pend_nx = pend | late;
    pend_line_nx = late ? tgt : pend_line;
    load = 1'b0;
    load_line = tgt;
    ready_nx = line_ready;
    if (state == IDLE && trig) begin
      state_nx = REQ;
      idx_nx = '0;
      load = 1'b1;
      ready_nx = 1'b0;
    end else if (state == REQ && rd_ack) begin
      state_nx = WAIT;
    end else if (state == WAIT && rd_done) begin
      // A late trigger restarts on the new line only once the in-flight burst is done.
      if (enable && pend_nx) begin
        state_nx = REQ;
        idx_nx = '0;
        load = 1'b1;
        load_line = pend_line_nx;
        pend_nx = 1'b0;
        ready_nx = 1'b0;
      end else if (burst_idx == LAST_IDX) begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        pend_nx = 1'b0;
      end else if (!enable) begin
        state_nx = IDLE;
        pend_nx = 1'b0;
      end else begin
        state_nx = REQ;
        idx_nx = burst_idx + 7'd1;
      end
    end
    if (swap) ready_nx = 1'b0;
    und_nx = (late || (swap && !line_ready && enable)) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      burst_idx <= '0;
      disp_buf <= 1'b0;
      line_ready <= 1'b0;
      underrun <= 1'b0;
      pend <= 1'b0;
      pend_line <= '0;
    end else begin
      state <= state_nx;
      burst_idx <= idx_nx;
      disp_buf <= disp_buf ^ swap;
      line_ready <= ready_nx;
      underrun <= und_nx;
      pend <= pend_nx;
      pend_line <= pend_line_nx;
    end
  line_addr_gen #(.FB_BASE(FB_BASE), .LINE_STRIDE(LINE_STRIDE)) u_addr (
    .clk(clk),
    .reset(reset),
    .load(load),
    .line(load_line),
    .burst_idx(burst_idx),
    .addr(rd_addr)
  );
endmodule

// File: tb/tb_line_fetch_scheduler.sv
// tb_line_fetch_scheduler: scoreboard bench with an SDRAM model and a pixel-position driver
module tb_line_fetch_scheduler;
  import vga_pkg::*;
  logic clk = 1'b0, reset = 1'b1, clk_stb = 1'b0, enable = 1'b0;
  logic rd_ack = 1'b0, rd_done = 1'b0, underrun_clr = 1'b0;
  logic [10:0] hpos = '0, vpos = '0;
  logic rd_req, wr_buf, disp_buf, line_ready, underrun;
  logic [ADDR_W-1:0] rd_addr;
  logic [6:0] burst_idx;
  int n_chk = 0, n_err = 0, div = 1, ack_lat = 2, done_lat = 10, mphase = 0, mcnt = 0;
  bit hold = 0, exp_disp = 0;
  int q_addr[$], q_idx[$];
  always #5 clk = ~clk;
  line_fetch_scheduler dut (
    .clk(clk), .reset(reset), .clk_stb(clk_stb), .hpos(hpos), .vpos(vpos), .enable(enable),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
    .wr_buf(wr_buf), .burst_idx(burst_idx), .disp_buf(disp_buf), .line_ready(line_ready),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string t);
    chk({t, "_req"}, rd_req, 0);
    chk({t, "_addr"}, rd_addr, 0);
    chk({t, "_idx"}, burst_idx, 0);
    chk({t, "_disp"}, disp_buf, 0);
    chk({t, "_wrbuf"}, wr_buf, 1);
    chk({t, "_ready"}, line_ready, 0);
    chk({t, "_und"}, underrun, 0);
  endtask
  function automatic bit vis(input int v);
    return v <= V_DISPLAY - 2 || v == V_MAX;
  endfunction
  task automatic push_line(input int line);
    for (int i = 0; i < BURSTS_PER_LINE; i++) begin
      q_addr.push_back(line * 640 + i * BURST_LEN);
      q_idx.push_back(i);
    end
  endtask
  task automatic goto(input int v, input int h);
    vpos = 11'(v);
    hpos = 11'(h);
  endtask
  task automatic pix();
    if (hpos == 11'(H_DISPLAY) && enable && vis(int'(vpos))) push_line(vpos == 11'(V_MAX) ? 0 : int'(vpos) + 1);
    if (hpos == 11'(H_MAX) && vis(int'(vpos))) exp_disp = !exp_disp;
    clk_stb = 1'b1;
    @(negedge clk);
    clk_stb = 1'b0;
    repeat (div - 1) @(negedge clk);
    if (hpos == 11'(H_MAX)) begin
      hpos = '0;
      vpos = (vpos == 11'(V_MAX)) ? 11'd0 : vpos + 11'd1;
    end else hpos = hpos + 11'd1;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((q_addr.size() != 0 || mphase != 0 || rd_req) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 3000, 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_busy(input string tag);
    int n = 0;
    while (mphase != 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 500, 1);
    @(negedge clk);
  endtask
  task automatic flush();
    q_addr.delete();
    q_idx.delete();
  endtask
  initial forever begin
    @(negedge clk);
    rd_ack = 1'b0;
    rd_done = 1'b0;
    if (!reset) mphase = 0;
    else if (mphase == 0) begin
      if (rd_req) begin
        mcnt = ack_lat;
        mphase = 1;
      end
    end else if (mphase == 1) begin
      mcnt--;
      if (mcnt <= 0) begin
        rd_ack = 1'b1;
        mphase = 2;
        mcnt = done_lat;
        chk("req_held", rd_req, 1);
        chk("req_expected", q_addr.size() != 0, 1);
        if (q_addr.size() != 0) begin
          chk("rd_addr", rd_addr, q_addr.pop_front());
          chk("burst_idx", burst_idx, q_idx.pop_front());
        end
      end
    end else if (!hold) begin
      mcnt--;
      if (mcnt <= 0) begin
        rd_done = 1'b1;
        mphase = 0;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached before end of test");
    $fatal(1);
  end
  initial begin
    enable = 1'b1;
    #1 reset = 1'b0;
    #2 chk_idle("rst0");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    div = 10;
    goto(10, H_DISPLAY);
    pix();
    while (hpos != 11'(H_MAX)) pix();
    chk("ready_before_swap", line_ready, 1);
    chk("queue_normal", q_addr.size(), 0);
    pix();
    chk("disp_swap", disp_buf, exp_disp);
    chk("wr_buf_swap", wr_buf, !exp_disp);
    chk("ready_cleared", line_ready, 0);
    chk("und_normal", underrun, 0);
    div = 1;
    goto(V_MAX, H_DISPLAY);
    pix();
    drain("drain_wrap");
    chk("ready_wrap", line_ready, 1);
    goto(479, H_DISPLAY);
    pix();
    repeat (30) @(negedge clk);
    chk("no_req_479", rd_req, 0);
    done_lat = 40;
    goto(20, H_DISPLAY);
    pix();
    while (hpos != 11'(H_MAX)) pix();
    chk("ready_slow", line_ready, 0);
    pix();
    chk("und_slow", underrun, 1);
    chk("disp_slow", disp_buf, exp_disp);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("und_clr", underrun, 0);
    hold = 1;
    wait_busy("busy_late");
    flush();
    goto(21, H_DISPLAY);
    pix();
    chk("und_late", underrun, 1);
    chk("req_late_hold", rd_req, 0);
    done_lat = 10;
    hold = 0;
    drain("drain_late");
    chk("ready_late", line_ready, 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("und_clr2", underrun, 0);
    goto(30, H_DISPLAY);
    pix();
    repeat (40) @(negedge clk);
    hold = 1;
    wait_busy("busy_off");
    flush();
    enable = 1'b0;
    hold = 0;
    repeat (100) @(negedge clk);
    chk("req_off", rd_req, 0);
    chk("ready_off", line_ready, 0);
    chk("mem_idle_off", mphase, 0);
    goto(30, H_MAX);
    pix();
    chk("und_off", underrun, 0);
    chk("disp_off", disp_buf, exp_disp);
    goto(31, H_DISPLAY);
    pix();
    repeat (30) @(negedge clk);
    chk("no_trig_off", rd_req, 0);
    enable = 1'b1;
    goto(40, H_DISPLAY);
    pix();
    chk("req_pre_rst", rd_req, 1);
    #2 reset = 1'b0;
    exp_disp = 0;
    #1 chk_idle("rst_mid");
    @(negedge clk);
    flush();
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("req_post_rst", rd_req, 0);
    goto(41, H_DISPLAY);
    pix();
    drain("drain_post_rst");
    chk("ready_post_rst", line_ready, 1);
    chk("queue_end", q_addr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
